// File: rtl/counter_pkg.sv
// Shared types and parameter checking for the up/down modulo counter family.
package counter_pkg;

   // Count direction as sampled from the 'up' input.
   typedef enum logic {
      CNT_DOWN = 1'b0,
      CNT_UP   = 1'b1
   } count_dir_e;

   // Behaviour at the count boundary.
   typedef enum logic {
      CNT_WRAP = 1'b0,
      CNT_SAT  = 1'b1
   } count_mode_e;

   // True when the WIDTH / MAX_VAL / PRESCALE combination is usable.
   // Width is capped so the 64-bit range computation below cannot overflow.
   function automatic logic counter_params_ok(input int     width,
                                              input longint max_val,
                                              input int     prescale);
      logic ok;
      ok = 1'b1;
      if ((width < 32'sd2) || (width > 32'sd62)) begin
         ok = 1'b0;
      end else if ((max_val < 64'sd1) ||
                   (max_val > ((64'sd1 <<< width) - 64'sd1))) begin
         ok = 1'b0;
      end else if (prescale < 32'sd1) begin
         ok = 1'b0;
      end else begin
         ok = 1'b1;
      end
      return ok;
   endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Clock-enable prescaler: produces one tick every PRESCALE enabled cycles.
// A synchronous clear (clear or load of the parent counter) restarts the phase.
module counter_prescaler #(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic sync_clr,
   input  logic enable,
   output logic tick
);

   localparam int            PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] LP_LAST = PW'(PRESCALE - 1);
   localparam logic [PW-1:0] LP_ONE  = PW'(1);
   localparam logic [PW-1:0] LP_ZERO = {PW{1'b0}};

   logic [PW-1:0] r_phase;
   logic [PW-1:0] w_phase_nxt;
   logic          w_last;

   assign w_last = (r_phase == LP_LAST);
   // A tick is suppressed on clear/load edges so those always win over a step.
   assign tick   = enable & ~sync_clr & w_last;

   // Next phase: restart on clear, advance on enable, hold otherwise.
   always_comb begin
      w_phase_nxt = r_phase;
      if (sync_clr) begin
         w_phase_nxt = LP_ZERO;
      end else if (enable) begin
         if (w_last) begin
            w_phase_nxt = LP_ZERO;
         end else begin
            w_phase_nxt = r_phase + LP_ONE;
         end
      end else begin
         w_phase_nxt = r_phase;
      end
   end

   // Phase register with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_phase <= LP_ZERO;
      end else begin
         r_phase <= w_phase_nxt;
      end
   end

endmodule

// File: rtl/mod_updown_counter.sv
// Parametrised up/down modulo counter (0..MAX_VAL) with prescaled enable,
// one-cycle terminal-count pulse and sticky overflow flag.
// Optional feature macro: MUDC_SATURATE_EN adds the sat_mode input, which
// selects saturate instead of wrap at the boundary. Without it the counter
// always wraps.
module mod_updown_counter
   import counter_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int MAX_VAL  = (2 ** WIDTH) - 1,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] start_val,
   input  logic             enable,
   input  logic             up,
`ifdef MUDC_SATURATE_EN
   input  logic             sat_mode,
`endif
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             ovf
);

   // All comparisons and +/-1 arithmetic run one bit wider than the count.
   localparam logic [WIDTH:0] LP_MAX  = (WIDTH + 1)'(MAX_VAL);
   localparam logic [WIDTH:0] LP_ONE  = (WIDTH + 1)'(1);
   localparam logic [WIDTH:0] LP_ZERO = {(WIDTH + 1){1'b0}};

   generate
      if (!counter_params_ok(WIDTH, longint'(MAX_VAL), PRESCALE)) begin : g_bad_params
         $error("mod_updown_counter: illegal WIDTH/MAX_VAL/PRESCALE combination");
      end
   endgenerate

   logic [WIDTH-1:0] r_count;
   logic             r_tc;
   logic             r_ovf;

   logic             w_tick;
   logic             w_sync_clr;
   logic [WIDTH:0]   w_cur;
   logic [WIDTH:0]   w_start;
   count_dir_e       w_dir;
   count_mode_e      w_mode;
   logic [WIDTH-1:0] w_count_nxt;
   logic             w_tc_nxt;
   logic             w_ovf_nxt;

   assign w_sync_clr = clear | load;
   assign w_cur      = {1'b0, r_count};
   assign w_start    = {1'b0, start_val};
   assign w_dir      = up ? CNT_UP : CNT_DOWN;

`ifdef MUDC_SATURATE_EN
   assign w_mode = sat_mode ? CNT_SAT : CNT_WRAP;
`else
   assign w_mode = CNT_WRAP;
`endif

   counter_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk      (clk),
      .rst      (rst),
      .sync_clr (w_sync_clr),
      .enable   (enable),
      .tick     (w_tick)
   );

   // Next count/tc/ovf with priority clear > load > step > hold.
   always_comb begin
      w_count_nxt = r_count;
      w_tc_nxt    = 1'b0;
      w_ovf_nxt   = r_ovf;
      if (clear) begin
         w_count_nxt = {WIDTH{1'b0}};
         w_ovf_nxt   = 1'b0;
      end else if (load) begin
         // Out-of-range load values clamp to the top of the sequence.
         if (w_start > LP_MAX) begin
            w_count_nxt = WIDTH'(LP_MAX);
         end else begin
            w_count_nxt = start_val;
         end
      end else if (w_tick) begin
         case (w_dir)
            CNT_UP: begin
               if (w_cur == LP_MAX) begin
                  w_tc_nxt  = 1'b1;
                  w_ovf_nxt = 1'b1;
                  if (w_mode == CNT_SAT) begin
                     w_count_nxt = r_count;
                  end else begin
                     w_count_nxt = {WIDTH{1'b0}};
                  end
               end else begin
                  w_count_nxt = WIDTH'(w_cur + LP_ONE);
               end
            end
            CNT_DOWN: begin
               if (w_cur == LP_ZERO) begin
                  w_tc_nxt  = 1'b1;
                  w_ovf_nxt = 1'b1;
                  if (w_mode == CNT_SAT) begin
                     w_count_nxt = r_count;
                  end else begin
                     w_count_nxt = WIDTH'(LP_MAX);
                  end
               end else begin
                  w_count_nxt = WIDTH'(w_cur - LP_ONE);
               end
            end
            default: begin
               w_count_nxt = r_count;
            end
         endcase
      end else begin
         w_count_nxt = r_count;
      end
   end

   // Output state registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= {WIDTH{1'b0}};
         r_tc    <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_count <= w_count_nxt;
         r_tc    <= w_tc_nxt;
         r_ovf   <= w_ovf_nxt;
      end
   end

   assign count = r_count;
   assign tc    = r_tc;
   assign ovf   = r_ovf;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: two instances (PRESCALE 1 and 3, WIDTH 5,
// MAX_VAL 23), a behavioural model compared every negedge, directed vectors
// with literal expectations, then a pseudo-random phase.
module tb_mod_updown_counter;

   localparam int MAXV = 23;
   localparam int PS_A = 1;
   localparam int PS_B = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clear_v [2];
   logic       load_v  [2];
   logic       en_v    [2];
   logic       up_v    [2];
   logic [4:0] start_v [2];
`ifdef MUDC_SATURATE_EN
   logic       sat_v   [2];
`endif
   logic [4:0] cnt_o   [2];
   logic       tc_o    [2];
   logic       ovf_o   [2];

   int e_cnt [2] = '{0, 0};
   int e_ph  [2] = '{0, 0};
   int e_tc  [2] = '{0, 0};
   int e_ovf [2] = '{0, 0};

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mod_updown_counter #(.WIDTH(5), .MAX_VAL(MAXV), .PRESCALE(PS_A)) dut_a (
      .clk(clk), .rst(rst), .clear(clear_v[0]), .load(load_v[0]),
      .start_val(start_v[0]), .enable(en_v[0]), .up(up_v[0]),
`ifdef MUDC_SATURATE_EN
      .sat_mode(sat_v[0]),
`endif
      .count(cnt_o[0]), .tc(tc_o[0]), .ovf(ovf_o[0])
   );

   mod_updown_counter #(.WIDTH(5), .MAX_VAL(MAXV), .PRESCALE(PS_B)) dut_b (
      .clk(clk), .rst(rst), .clear(clear_v[1]), .load(load_v[1]),
      .start_val(start_v[1]), .enable(en_v[1]), .up(up_v[1]),
`ifdef MUDC_SATURATE_EN
      .sat_mode(sat_v[1]),
`endif
      .count(cnt_o[1]), .tc(tc_o[1]), .ovf(ovf_o[1])
   );

   task automatic chk(input string nm, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp_v, $time);
      end
   endtask

   task automatic chk3(input string nm, input int k, input int c, input int t, input int o);
      chk({nm, "_count"}, int'(cnt_o[k]), c);
      chk({nm, "_tc"},    int'(tc_o[k]),  t);
      chk({nm, "_ovf"},   int'(ovf_o[k]), o);
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
      end
      #1;
   endtask

   // Behavioural model: counts in plain integers following the rules.
   always @(posedge clk or posedge rst) begin : model
      int c, ph, o, t, s, ps;
      for (int k = 0; k < 2; k++) begin
         c  = e_cnt[k];
         ph = e_ph[k];
         o  = e_ovf[k];
         t  = 0;
         ps = (k == 0) ? PS_A : PS_B;
`ifdef MUDC_SATURATE_EN
         s  = int'(sat_v[k]);
`else
         s  = 0;
`endif
         if (rst) begin
            c = 0; ph = 0; o = 0;
         end else if (clear_v[k]) begin
            c = 0; ph = 0; o = 0;
         end else if (load_v[k]) begin
            c  = (int'(start_v[k]) > MAXV) ? MAXV : int'(start_v[k]);
            ph = 0;
         end else if (en_v[k]) begin
            ph = ph + 1;
            if (ph == ps) begin
               ph = 0;
               if (up_v[k]) begin
                  if (c == MAXV) begin
                     t = 1; o = 1; c = (s != 0) ? MAXV : 0;
                  end else begin
                     c = c + 1;
                  end
               end else begin
                  if (c == 0) begin
                     t = 1; o = 1; c = (s != 0) ? 0 : MAXV;
                  end else begin
                     c = c - 1;
                  end
               end
            end
         end
         e_cnt[k] <= c;
         e_ph[k]  <= ph;
         e_tc[k]  <= t;
         e_ovf[k] <= o;
      end
   end

   // Every-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (!rst) begin
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("cmp%0d_count", k), int'(cnt_o[k]), e_cnt[k]);
            chk($sformatf("cmp%0d_tc", k),    int'(tc_o[k]),   e_tc[k]);
            chk($sformatf("cmp%0d_ovf", k),   int'(ovf_o[k]),  e_ovf[k]);
         end
      end
   end

   initial begin
      for (int k = 0; k < 2; k++) begin
         clear_v[k] = 1'b0; load_v[k] = 1'b0; en_v[k] = 1'b0;
         up_v[k] = 1'b1; start_v[k] = 5'd0;
`ifdef MUDC_SATURATE_EN
         sat_v[k] = 1'b0;
`endif
      end
      cyc(2);
      rst = 1'b0;
      chk3("reset_a", 0, 0, 0, 0);
      chk3("reset_b", 1, 0, 0, 0);

      // Up wrap from 21.
      start_v[0] = 5'd21; load_v[0] = 1'b1; cyc(1);
      chk3("upload", 0, 21, 0, 0);
      load_v[0] = 1'b0; en_v[0] = 1'b1; up_v[0] = 1'b1;
      cyc(1); chk3("up1", 0, 22, 0, 0);
      cyc(1); chk3("up2", 0, 23, 0, 0);
      cyc(1); chk3("up3", 0, 0, 1, 1);
      cyc(1); chk3("up4", 0, 1, 0, 1);
      chk("model_up4", e_cnt[0], 1);
      en_v[0] = 1'b0;

      // Load 7 then asynchronous reset between edges.
      start_v[0] = 5'd7; load_v[0] = 1'b1; cyc(1); load_v[0] = 1'b0;
      chk3("pre_rst", 0, 7, 0, 1);
      rst = 1'b1; #1;
      chk3("async_rst", 0, 0, 0, 0);
      #1 rst = 1'b0;

      // Down wrap from 1, then clear.
      start_v[0] = 5'd1; load_v[0] = 1'b1; up_v[0] = 1'b0; cyc(1);
      chk3("dnload", 0, 1, 0, 0);
      load_v[0] = 1'b0; en_v[0] = 1'b1;
      cyc(1); chk3("dn1", 0, 0, 0, 0);
      cyc(1); chk3("dn2", 0, 23, 1, 1);
      cyc(1); chk3("dn3", 0, 22, 0, 1);
      en_v[0] = 1'b0; clear_v[0] = 1'b1; cyc(1);
      chk3("clear", 0, 0, 0, 0);
      clear_v[0] = 1'b0;

      // Load clamp; load beats enable.
      start_v[0] = 5'd30; load_v[0] = 1'b1; en_v[0] = 1'b1; up_v[0] = 1'b1;
      cyc(1); chk3("clamp1", 0, 23, 0, 0);
      cyc(1); chk3("clamp2", 0, 23, 0, 0);
      load_v[0] = 1'b0; en_v[0] = 1'b0;

      // Prescale 3 on instance B, including an enable gap.
      en_v[1] = 1'b1; up_v[1] = 1'b1;
      cyc(2); chk3("ps_e2", 1, 0, 0, 0);
      cyc(1); chk3("ps_e3", 1, 1, 0, 0);
      chk("model_ps_e3", e_cnt[1], 1);
      cyc(2); chk3("ps_e5", 1, 1, 0, 0);
      en_v[1] = 1'b0; cyc(4); chk3("ps_hold", 1, 1, 0, 0);
      en_v[1] = 1'b1; cyc(1); chk3("ps_e6", 1, 2, 0, 0);
      // Load mid-phase restarts the prescaler.
      cyc(2); chk3("ps_mid", 1, 2, 0, 0);
      start_v[1] = 5'd5; load_v[1] = 1'b1; cyc(1);
      chk3("ps_load", 1, 5, 0, 0);
      load_v[1] = 1'b0;
      cyc(2); chk3("ps_l2", 1, 5, 0, 0);
      cyc(1); chk3("ps_l3", 1, 6, 0, 0);
      en_v[1] = 1'b0;

`ifdef MUDC_SATURATE_EN
      // Saturate at the top: tc repeats on each blocked step.
      sat_v[0] = 1'b1; start_v[0] = 5'd22; load_v[0] = 1'b1; cyc(1);
      load_v[0] = 1'b0; en_v[0] = 1'b1; up_v[0] = 1'b1;
      cyc(1); chk3("sat1", 0, 23, 0, 0);
      cyc(1); chk3("sat2", 0, 23, 1, 1);
      cyc(1); chk3("sat3", 0, 23, 1, 1);
      cyc(1); chk3("sat4", 0, 23, 1, 1);
      en_v[0] = 1'b0; up_v[0] = 1'b0; clear_v[0] = 1'b1; cyc(1);
      clear_v[0] = 1'b0; en_v[0] = 1'b1;
      cyc(1); chk3("satdn", 0, 0, 1, 1);
      en_v[0] = 1'b0; sat_v[0] = 1'b0;
`endif

      // Pseudo-random phase, checked by the model comparison.
      for (int i = 0; i < 400; i++) begin
         for (int k = 0; k < 2; k++) begin
            en_v[k]    = ($urandom_range(0, 3) != 0);
            up_v[k]    = ($urandom_range(0, 4) != 0);
            load_v[k]  = ($urandom_range(0, 19) == 0);
            clear_v[k] = ($urandom_range(0, 39) == 0);
            start_v[k] = 5'($urandom_range(0, 31));
`ifdef MUDC_SATURATE_EN
            sat_v[k]   = ($urandom_range(0, 1) != 0);
`endif
         end
         cyc(1);
      end
      for (int k = 0; k < 2; k++) begin
         en_v[k] = 1'b0; load_v[k] = 1'b0; clear_v[k] = 1'b0;
      end
      cyc(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mod_updown_counter.md
# mod_updown_counter

Parametrised up/down modulo counter: the next generation of the team's 5-bit rollover counter. It adds configurable width and modulus, a count direction, a clock-enable prescaler, a terminal-count pulse and a sticky overflow flag. It is a general-purpose timing/event-counting primitive for instantiation inside control blocks.

## Interface
- `WIDTH`, default 8: counter width in bits, ≥ 2.
- `MAX_VAL`, default 2**WIDTH-1: highest count value; the count sequence is 0..MAX_VAL. Must be 1 ≤ MAX_VAL ≤ 2**WIDTH-1.
- `PRESCALE`, default 1: number of enabled cycles per count step, ≥ 1.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `clear` input 1: synchronous clear of count, prescaler and `ovf`.
- `load` input 1: synchronous load of `start_val`.
- `start_val` input WIDTH: load value.
- `enable` input 1: advances the prescaler; a count step occurs on each prescaler tick.
- `up` input 1: 1 = increment, 0 = decrement; sampled on each step.
- `sat_mode` input 1: 1 = saturate, 0 = wrap. Present only with `MUDC_SATURATE_EN` defined.
- `count` output WIDTH: current count, registered.
- `tc` output 1: registered one-cycle terminal-count pulse.
- `ovf` output 1: sticky overflow/underflow flag, registered.

## Operation
- Reset (`rst`=1, asynchronous): `count`=0, `tc`=0, `ovf`=0, prescaler=0. Reset holds state while asserted.
- Per-edge priority: `clear` > `load` > step > hold.
- `clear`: `count`=0, prescaler=0, `ovf`=0, `tc`=0.
- `load`: `count`=min(`start_val`, `MAX_VAL`), prescaler=0, `tc`=0, `ovf` unchanged.
  - `load`=1 overrides `enable` regardless of prescaler state.
- Prescaler:
  - Internal counter 0..`PRESCALE`-1.
  - It advances only on edges where `enable`=1 and neither `clear` nor `load` is asserted.
  - Tick = `enable` and prescaler == `PRESCALE`-1; the prescaler returns to 0 on the tick.
  - With `PRESCALE`=1 every enabled cycle is a tick.
  - `enable`=0 holds the prescaler value; it does not reset it.
- Step, up direction:
  - `count`<`MAX_VAL`: count+1.
  - `count`==`MAX_VAL`: boundary event; count→0 (wrap) or held at `MAX_VAL` (saturate).
- Step, down direction:
  - `count`>0: count-1.
  - `count`==0: boundary event; count→`MAX_VAL` (wrap) or held at 0 (saturate).
- Boundary event: `tc`=1 for exactly the next cycle and `ovf` is set.
  - In saturate mode, `tc` pulses again on every further step attempted at the boundary.
- `tc`=0 on every edge without a boundary event.
- All arithmetic is done at WIDTH+1 bits internally. No intermediate result ever exceeds `MAX_VAL` or goes below 0.
- Changing `up` between steps is legal and takes effect on the next step.

## Timing
- One-cycle latency: a step or load on edge N is visible on `count` after edge N.
- `tc` and `ovf` update on the same edge as the boundary step.
- With `PRESCALE`=P and `enable` held at 1, `count` changes once every P cycles; the first change follows the P-th enabled edge after reset, clear or load.
- Reset asserted mid-count: outputs go to reset values immediately, without waiting for a clock edge.
- Reset release is synchronous to `clk`; the first step can occur on the first edge after release.

## Configuration
- `MUDC_SATURATE_EN` defined: the `sat_mode` port exists and selects wrap or saturate per cycle.
- `MUDC_SATURATE_EN` undefined: no `sat_mode` port; the block always wraps. Saturate logic is not synthesised.

## Structure
- Shared package `counter_pkg`:
  - `count_dir_e` enum (`CNT_DOWN`=0, `CNT_UP`=1).
  - `count_mode_e` enum (`CNT_WRAP`, `CNT_SAT`).
  - Parameter-check function `counter_params_ok(WIDTH, MAX_VAL, PRESCALE)`, used by an elaboration-time assertion.
- Sub-module `counter_prescaler`:
  - Parameter `PRESCALE`.
  - Inputs: `clk`, `rst`, `sync_clr` (`clear`|`load`), `enable`.
  - Output: `tick`.
  - Width is $clog2(PRESCALE), minimum 1.

## Test plan
All scenarios use WIDTH=5, MAX_VAL=23, PRESCALE=1 unless stated.
- Reset: assert `rst` mid-count with `count`=7, no clock edge → `count`=0, `tc`=0, `ovf`=0 immediately.
- Up wrap: load 21, `enable`=1, `up`=1 → `count` 22, 23, 0, 1; `tc` high only in the cycle `count`=0; `ovf`=1 afterwards.
- Down wrap, then clear: load 1, `up`=0 → `count` 0, 23, 22 with `tc` pulse at 23; then `clear` → `count`=0, `ovf`=0.
- Load clamp and priority: `start_val`=30, `load`=1, `enable`=1 for 2 cycles → `count`=23 both cycles, no step, `tc`=0.
- Prescale: PRESCALE=3, `enable`=1 from `count`=0 → `count` 1 after edge 3, 2 after edge 6. Dropping `enable` for 4 cycles in between holds both `count` and prescaler phase.
- Saturate (`MUDC_SATURATE_EN` defined, `sat_mode`=1): from 22 up, 4 steps → 23, 23, 23, 23; `tc` pulses on steps 2–4; `ovf`=1.
